// File: rtl/addr_mux_pkg.sv
// Shared constants and helpers for the round-robin address multiplexer.
package addr_mux_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 24;
  localparam int unsigned DEF_NUM_CH     = 4;

  // Channel-index width: clog2 of the channel count, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1, wrapping modulo NumCh.
module rr_arbiter
  import addr_mux_pkg::*;
#(
  parameter int unsigned NumCh = DEF_NUM_CH
) (
  input  logic [NumCh-1:0]          req,
  input  logic [ch_w(NumCh)-1:0]    last_grant,
  input  logic [NumCh-1:0]          mask,
  output logic [NumCh-1:0]          grant,
  output logic [ch_w(NumCh)-1:0]    grant_idx
);

  localparam int unsigned ChW = ch_w(NumCh);

  logic [NumCh-1:0] w_req;

  assign w_req = req & mask;

  // First eligible channel after the previous winner takes the grant.
  always_comb begin
    logic [ChW-1:0] v_idx;
    logic           v_found;
    grant     = '0;
    grant_idx = '0;
    v_idx     = '0;
    v_found   = 1'b0;
    for (int unsigned k = 1; k <= NumCh; k++) begin
      v_idx = ChW'((32'(last_grant) + k) % NumCh);
      if (!v_found && w_req[v_idx]) begin
        v_found        = 1'b1;
        grant[v_idx]   = 1'b1;
        grant_idx      = v_idx;
      end
    end
  end

endmodule

// File: rtl/addr_mux_arb.sv
// Registered N:1 address mux with round-robin arbitration and valid/ready handshake.
// Define ADDR_MUX_LOCK_EN to add the req_lock port and per-channel grant locking.
module addr_mux_arb
  import addr_mux_pkg::*;
#(
  parameter int unsigned AddrWidth = DEF_ADDR_WIDTH,
  parameter int unsigned NumCh     = DEF_NUM_CH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NumCh-1:0]             req_valid,
  input  logic [NumCh*AddrWidth-1:0]   req_addr,
  output logic [NumCh-1:0]             req_ready,
`ifdef ADDR_MUX_LOCK_EN
  input  logic [NumCh-1:0]             req_lock,
`endif
  output logic                         out_valid,
  output logic [AddrWidth-1:0]         out_addr,
  output logic [ch_w(NumCh)-1:0]       out_ch,
  input  logic                         out_ready
);

  localparam int unsigned ChW = ch_w(NumCh);

  logic [NumCh-1:0][AddrWidth-1:0] w_addr_arr;
  logic                            w_load_en;
  logic [NumCh-1:0]                w_mask;
  logic [NumCh-1:0]                w_grant;
  logic [ChW-1:0]                  w_grant_idx;
  logic                            w_any_grant;

  logic                            r_out_valid;
  logic [AddrWidth-1:0]            r_out_addr;
  logic [ChW-1:0]                  r_out_ch;
  logic [ChW-1:0]                  r_last_grant;

  assign w_addr_arr  = req_addr;
  assign w_load_en   = !r_out_valid || out_ready;
  assign w_any_grant = |w_grant;
  assign req_ready   = {NumCh{w_load_en}} & w_grant;

  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign out_ch    = r_out_ch;

`ifdef ADDR_MUX_LOCK_EN
  logic           r_lock_valid;
  logic [ChW-1:0] r_lock_ch;
  logic           w_lock_act;

  // A lock only holds while its owner keeps requesting.
  assign w_lock_act = r_lock_valid && req_valid[r_lock_ch];

  always_comb begin
    w_mask = '1;
    if (w_lock_act) begin
      w_mask            = '0;
      w_mask[r_lock_ch] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lock_valid <= 1'b0;
      r_lock_ch    <= '0;
    end else if (w_load_en && w_any_grant) begin
      r_lock_valid <= req_lock[w_grant_idx];
      r_lock_ch    <= w_grant_idx;
    end else if (!w_lock_act) begin
      r_lock_valid <= 1'b0;
    end
  end
`else
  assign w_mask = '1;
`endif

  rr_arbiter #(
    .NumCh      (NumCh)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .mask       (w_mask),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  // Output beat register; an empty grant on a load cycle drains the register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_ch     <= '0;
      r_last_grant <= ChW'(NumCh - 1);
    end else if (w_load_en) begin
      r_out_valid <= w_any_grant;
      if (w_any_grant) begin
        r_out_addr   <= w_addr_arr[w_grant_idx];
        r_out_ch     <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_addr_mux_arb.sv
// Self-checking bench for addr_mux_arb against a behavioural round-robin model.
module tb_addr_mux_arb;

  localparam int unsigned AW = 24;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 2;
`ifdef ADDR_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [NC-1:0]    req_valid;
  logic [NC*AW-1:0] req_addr;
  logic [NC-1:0]    req_ready;
  logic [NC-1:0]    req_lock;
  logic             out_valid;
  logic [AW-1:0]    out_addr;
  logic [CW-1:0]    out_ch;
  logic             out_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: the beat the output register should hold and the arbitration history.
  bit            m_valid;
  logic [AW-1:0] m_addr;
  int            m_ch;
  int            m_last;
  bit            m_lock_v;
  int            m_lock_ch;

  addr_mux_arb #(
    .AddrWidth (AW),
    .NumCh     (NC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
`ifdef ADDR_MUX_LOCK_EN
    .req_lock  (req_lock),
`endif
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [AW-1:0] addr_of(input int c);
    return req_addr[c*AW +: AW];
  endfunction

  function automatic int model_pick();
    bit lock_act;
    lock_act = LOCK_EN && m_lock_v && req_valid[m_lock_ch];
    for (int k = 1; k <= int'(NC); k++) begin
      int c;
      c = (m_last + k) % int'(NC);
      if (req_valid[c] && (!lock_act || c == m_lock_ch)) return c;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] model_ready();
    int g;
    logic [NC-1:0] r;
    g = model_pick();
    r = '0;
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_clock();
    int g;
    g = model_pick();
    if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid   = 1'b1;
        m_addr    = addr_of(g);
        m_ch      = g;
        m_last    = g;
        m_lock_v  = LOCK_EN && req_lock[g];
        m_lock_ch = g;
      end else begin
        m_valid  = 1'b0;
        m_lock_v = 1'b0;
      end
    end else if (m_lock_v && !req_valid[m_lock_ch]) begin
      m_lock_v = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_addr    = '0;
    m_ch      = 0;
    m_last    = int'(NC) - 1;
    m_lock_v  = 1'b0;
    m_lock_ch = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_lock  = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    req_addr = {$urandom, $urandom, $urandom};
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", out_addr); end
    n_cmp++; if (out_ch !== '0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", out_ch); end
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    @(posedge clock); model_clock(); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_rotation();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      req_valid = '1;
      req_addr  = {$urandom, $urandom, $urandom};
      out_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL rot_ready[%0d]: got %b want %b", i, req_ready, model_ready()); end
      @(posedge clock); model_clock(); #1;
      n_cmp++; if (out_ch !== CW'(exp_seq[i]) || out_valid !== 1'b1) begin
        n_err++; $display("FAIL rot_ch[%0d]: got ch %0d v %b want ch %0d v 1", i, out_ch, out_valid, exp_seq[i]);
      end
      n_cmp++; if (out_addr !== m_addr) begin n_err++; $display("FAIL rot_addr[%0d]: got %h want %h", i, out_addr, m_addr); end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      req_valid = 4'b0100;
      req_addr  = {$urandom, $urandom, $urandom};
      req_addr[2*AW +: AW] = 24'hABCDEF;
      out_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready[%0d]: got %b want 0100", i, req_ready); end
      @(posedge clock); model_clock(); #1;
      n_cmp++; if ({out_valid, out_ch, out_addr} !== {1'b1, 2'd2, 24'hABCDEF}) begin
        n_err++; $display("FAIL single_beat[%0d]: got v%b ch%0d %h want v1 ch2 abcdef", i, out_valid, out_ch, out_addr);
      end
    end
  endtask

  task automatic test_stall();
    logic [CW-1:0]  h_ch;
    logic [AW-1:0]  h_addr;
    int             nxt;
    logic [NC-1:0]  exp_rdy;
    @(negedge clock);
    req_valid = '1;
    req_addr  = {$urandom, $urandom, $urandom};
    out_ready = 1'b1;
    @(posedge clock); model_clock(); #1;
    n_cmp++; if ({out_valid, out_ch, out_addr} !== {1'b1, CW'(m_ch), m_addr}) begin
      n_err++; $display("FAIL stall_load: got v%b ch%0d %h want v1 ch%0d %h", out_valid, out_ch, out_addr, m_ch, m_addr);
    end
    h_ch   = out_ch;
    h_addr = out_addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      out_ready = 1'b0;
      req_addr  = {$urandom, $urandom, $urandom};
      #1;
      n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, req_ready); end
      @(posedge clock); model_clock(); #1;
      n_cmp++; if ({out_valid, out_ch, out_addr} !== {1'b1, h_ch, h_addr}) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v%b ch%0d %h want v1 ch%0d %h", i, out_valid, out_ch, out_addr, h_ch, h_addr);
      end
    end
    @(negedge clock);
    out_ready = 1'b1;
    nxt = (int'(h_ch) + 1) % int'(NC);
    exp_rdy = NC'(1) << nxt;
    #1;
    n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL release_ready: got %b want %b", req_ready, exp_rdy); end
    @(posedge clock); model_clock(); #1;
    n_cmp++; if ({out_valid, out_ch, out_addr} !== {1'b1, CW'(nxt), addr_of(nxt)}) begin
      n_err++; $display("FAIL release_beat: got v%b ch%0d %h want v1 ch%0d %h", out_valid, out_ch, out_addr, nxt, addr_of(nxt));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    req_valid = '1;
    req_addr  = {$urandom, $urandom, $urandom};
    out_ready = 1'b1;
    @(posedge clock); model_clock(); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_cmp++; if ({out_valid, out_ch, out_addr} !== {1'b0, 2'd0, 24'd0}) begin
      n_err++; $display("FAIL mid_reset: got v%b ch%0d %h want v0 ch0 000000", out_valid, out_ch, out_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    req_valid = '1;
    req_addr  = {$urandom, $urandom, $urandom};
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ready: got %b want 0001", req_ready); end
    @(posedge clock); model_clock(); #1;
    n_cmp++; if ({out_valid, out_ch, out_addr} !== {1'b1, 2'd0, addr_of(0)}) begin
      n_err++; $display("FAIL mid_first: got v%b ch%0d %h want v1 ch0 %h", out_valid, out_ch, out_addr, addr_of(0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      req_valid = NC'($urandom);
      req_addr  = {$urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      req_lock  = LOCK_EN ? (NC'($urandom) & NC'($urandom)) : '0;
      #1;
      n_cmp++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, model_ready()); end
      @(posedge clock); model_clock(); #1;
      n_cmp++; if ({out_valid, out_ch, out_addr} !== {m_valid, CW'(m_ch), m_addr}) begin
        n_err++; $display("FAIL rand_beat[%0d]: got v%b ch%0d %h want v%b ch%0d %h", i, out_valid, out_ch, out_addr, m_valid, m_ch, m_addr);
      end
    end
  endtask

`ifdef ADDR_MUX_LOCK_EN
  task automatic test_lock();
    int       exp_seq[5]  = '{1, 1, 1, 1, 3};
    bit [3:0] valid_seq[5] = '{4'b0010, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    bit [3:0] lock_seq[5]  = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      req_valid = valid_seq[i];
      req_lock  = lock_seq[i];
      req_addr  = {$urandom, $urandom, $urandom};
      out_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL lock_ready[%0d]: got %b want %b", i, req_ready, model_ready()); end
      @(posedge clock); model_clock(); #1;
      n_cmp++; if ({out_valid, out_ch} !== {1'b1, CW'(exp_seq[i])}) begin
        n_err++; $display("FAIL lock_ch[%0d]: got v%b ch%0d want v1 ch%0d", i, out_valid, out_ch, exp_seq[i]);
      end
      n_cmp++; if (out_addr !== m_addr) begin n_err++; $display("FAIL lock_addr[%0d]: got %h want %h", i, out_addr, m_addr); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef ADDR_MUX_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
